dropout_mask_sched: RTL
=======================

Name: dropout_mask_sched

Overview:
- Controller that sequences dropout across a multi-layer network pass.
- For each layer, generates an N-lane keep/drop mask from an on-chip 16-bit LFSR compared against a programmable per-layer threshold.
- Presents each mask to the dropout datapath over a valid/ready handshake.
- In inference mode, emits all-keep masks without consuming randomness. Sits between the training sequencer (start/done) and the per-layer dropout units.

Parameters:
- N, 8, number of lanes (neurons) per mask.
- LAYERS, 4, number of layers sequenced per pass (≥1).
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
- THRESH_RST, 16'h8000, per-layer threshold after reset (50% drop rate).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins one pass over all layers.
- train_en  in  1  1 = training (random masks), 0 = inference (all-keep); sampled on accepted start.
- cfg_we  in  1  threshold write strobe.
- cfg_layer  in  LW=max(1,$clog2(LAYERS))  layer index for the write.
- cfg_thresh  in  16  drop threshold: lane dropped iff rand < thresh.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last mask handshake.
- mask_valid  out  1  mask is available.
- mask_ready  in  1  datapath accepts the mask.
- mask  out  N  bit i = 1 keep lane i, 0 drop.
- mask_layer  out  LW  layer the current mask belongs to.

Behaviour:
- Reset values: busy=0, done=0, mask_valid=0, mask=all-ones, mask_layer=0, LFSR=SEED (or 1 if SEED=0), all thresholds=THRESH_RST, state=IDLE.
  - Reset mid-pass aborts the pass immediately; no done pulse is produced.
- LFSR: 16-bit Galois, taps 16'hB400. Shifts exactly once per GEN cycle and never in any other state. Never reaches zero.
- FSM states: IDLE, GEN, PRESENT, FIN.
  - IDLE: start=1 → latch train_en into mode, layer=0, busy=1. If mode=1, go to GEN and latch thr_cur=thresh[0]. If mode=0, go to PRESENT with mask=all-ones.
  - GEN: runs N cycles (lane counter 0..N-1). Each cycle sets mask[lane] = (lfsr_cur >= thr_cur), then shifts the LFSR. After lane N-1, go to PRESENT.
  - PRESENT: mask_valid=1, with mask and mask_layer stable until mask_valid && mask_ready.
    - On handshake with layer<LAYERS-1: layer++ and return to GEN (latching the new threshold), or stay in PRESENT with all-ones when mode=0.
    - On handshake with layer=LAYERS-1: go to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Latency (training): start accepted at cycle t; GEN occupies t+1..t+N; mask_valid first high at t+N+1. Inference: mask_valid at t+1.
- mask_valid is deasserted in the cycle after a handshake. There is no back-to-back presentation in training mode; in inference mode mask_valid may stay high across layers.
- start while busy is ignored. train_en changes mid-pass are ignored.
- cfg writes are accepted in any state. cfg_layer ≥ LAYERS is ignored.
  - A write to the layer currently in GEN does not affect that mask, because the threshold is latched at GEN entry.
  - A write in the same cycle as GEN entry for that layer: GEN uses the old value.
- Threshold boundaries:
  - thresh=0 → never drop.
  - thresh=16'hFFFF → drop unless rand=16'hFFFF.
- Widths: comparisons are unsigned 16-bit. The lane counter is $clog2(N)+1 bits; no wrap concerns.

Optional Feature:
- Macro DROPOUT_MIN_KEEP_EN.
  - Defined: when GEN completes with an all-zero mask, mask[0] is forced to 1 before PRESENT. No extra cycle; the LFSR is unaffected.
  - Undefined: all-zero masks pass through unchanged.

Decomposition:
- Package dropout_pkg holds:
  - state enum {IDLE, GEN, PRESENT, FIN};
  - LFSR_TAPS = 16'hB400;
  - THRESH_W = 16;
  - default threshold constant.
- One sub-module, dropout_lfsr: 16-bit Galois LFSR with ports clk, reset, step, seed parameter, and value output.

Test Plan:
- Reset → mask_valid=0, busy=0, mask=FF, mask_layer=0; after 20 idle cycles the LFSR value is unchanged (no GEN).
- train_en=0, start, mask_ready=1 → 4 masks of 8'hFF on layers 0..3 on consecutive cycles t+1..t+4; done at t+5; LFSR unchanged.
- cfg thresh[0]=0, thresh[1]=16'hFFFF, train_en=1, start, mask_ready=1:
  - layer 0 mask=8'hFF, first valid at t+9;
  - layer 1 mask matches the reference model (zero unless the LFSR hits FFFF);
  - LFSR has advanced 32 steps at done.
- Hold mask_ready=0 for 5 cycles in PRESENT → mask, mask_layer, mask_valid stable; a start pulse during the stall is ignored; done occurs exactly once.
- Assert reset mid-GEN of layer 2 → next cycle busy=0, mask_valid=0, thresholds back to 16'h8000; the following pass reproduces the first-pass masks bit-exactly (SEED restored).
- DROPOUT_MIN_KEEP_EN defined, thresh[0]=16'hFFFF → layer 0 mask=8'h01. Undefined → 8'h00.

Source files
------------

// File: rtl/dropout_pkg.sv
// Shared types and constants for the dropout mask scheduler.
// The optional macro DROPOUT_MIN_KEEP_EN is consumed by dropout_mask_sched.
package dropout_pkg;

   typedef enum logic [1:0] {IDLE, GEN, PRESENT, FIN} state_t;

   localparam int          THRESH_W       = 16;
   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [THRESH_W-1:0] THRESH_DEFAULT = 16'h8000;

endpackage

// File: rtl/dropout_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances only when step is high.
// A zero seed is replaced by 1 so the register can never lock up at zero.
module dropout_lfsr
   import dropout_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step,
   output logic [15:0] value
);

   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] r_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= SEED_NZ;
      end else if (step) begin
         r_value <= r_value[0] ? ((r_value >> 1) ^ LFSR_TAPS) : (r_value >> 1);
      end
   end

   assign value = r_value;

endmodule

// File: rtl/dropout_mask_sched.sv
// Sequences per-layer keep/drop masks for one network pass (LFSR vs threshold).
// Optional macro DROPOUT_MIN_KEEP_EN: an all-drop training mask keeps lane 0.
module dropout_mask_sched
   import dropout_pkg::*;
#(
   parameter int                    N          = 8,
   parameter int                    LAYERS     = 4,
   parameter logic [15:0]           SEED       = 16'hACE1,
   parameter logic [THRESH_W-1:0]   THRESH_RST = THRESH_DEFAULT,
   localparam int                   LW         = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                train_en,
   input  logic                cfg_we,
   input  logic [LW-1:0]       cfg_layer,
   input  logic [THRESH_W-1:0] cfg_thresh,
   output logic                busy,
   output logic                done,
   output logic                mask_valid,
   input  logic                mask_ready,
   output logic [N-1:0]        mask,
   output logic [LW-1:0]       mask_layer,
   output state_t              dbg_state
);

   localparam int CW = $clog2(N) + 1;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   // Handshake: a mask transfers on a cycle where mask_valid && mask_ready;
   // mask and mask_layer are held constant while mask_valid is high.

   state_t              r_state;
   state_t              w_state_next;
   logic                r_mode;
   logic [LW-1:0]       r_layer;
   logic [CW-1:0]       r_lane;
   logic [N-1:0]        r_mask;
   logic [THRESH_W-1:0] r_thr_cur;
   logic [THRESH_W-1:0] r_thresh [LAYERS];

   logic [15:0]         w_lfsr;
   logic [IW-1:0]       w_lane_idx;
   logic [N-1:0]        w_mask_gen;
   logic [LW-1:0]       w_layer_inc;
   logic                w_last_lane;
   logic                w_last_layer;

   dropout_lfsr #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .step  (r_state == GEN),
      .value (w_lfsr)
   );

   assign w_lane_idx   = IW'(r_lane);
   assign w_layer_inc  = r_layer + LW'(1);
   assign w_last_lane  = (r_lane == CW'(N - 1));
   assign w_last_layer = (r_layer == LW'(LAYERS - 1));

   always_comb begin
      w_mask_gen             = r_mask;
      w_mask_gen[w_lane_idx] = (w_lfsr >= r_thr_cur);
`ifdef DROPOUT_MIN_KEEP_EN
      if (w_last_lane && (w_mask_gen == '0)) begin
         w_mask_gen[0] = 1'b1;
      end
`endif
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = train_en ? GEN : PRESENT;
         GEN:     if (w_last_lane) w_state_next = PRESENT;
         PRESENT: begin
            if (mask_ready) begin
               if (w_last_layer) w_state_next = FIN;
               else if (r_mode)  w_state_next = GEN;
               else              w_state_next = PRESENT;
            end
         end
         FIN:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode    <= 1'b0;
         r_layer   <= '0;
         r_lane    <= '0;
         r_mask    <= '1;
         r_thr_cur <= THRESH_RST;
         for (int i = 0; i < LAYERS; i++) r_thresh[i] <= THRESH_RST;
      end else begin
         // Thresholds are latched at GEN entry, so a write here never alters a mask in flight.
         if (cfg_we && (32'(cfg_layer) < LAYERS)) r_thresh[cfg_layer] <= cfg_thresh;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode    <= train_en;
                  r_layer   <= '0;
                  r_lane    <= '0;
                  r_thr_cur <= r_thresh[0];
                  if (!train_en) r_mask <= '1;
               end
            end
            GEN: begin
               r_mask <= w_mask_gen;
               r_lane <= r_lane + CW'(1);
            end
            PRESENT: begin
               if (mask_ready && !w_last_layer) begin
                  r_layer   <= w_layer_inc;
                  r_lane    <= '0;
                  r_thr_cur <= r_thresh[w_layer_inc];
                  if (!r_mode) r_mask <= '1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = (r_state == GEN) || (r_state == PRESENT);
   assign done       = (r_state == FIN);
   assign mask_valid = (r_state == PRESENT);
   assign mask       = r_mask;
   assign mask_layer = r_layer;
   assign dbg_state  = r_state;

endmodule
